// File: rtl/frame_line_buffer.sv
// One-frame byte buffer: writes 2**WR_AW bytes, then reads them back as RDW-bit little-endian words.
// Read latency 1 cycle; no backpressure, the frame streams at one byte or one word per cycle.
module frame_line_buffer #(
  parameter int WR_AW  = 11,
  parameter int RD_AW  = 9,
  parameter int DW     = 8,
  parameter int RDW    = 32,
  parameter int ROW_WL = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [DW-1:0]             din,
  output logic                      ena,
  output logic                      wea,
  output logic [WR_AW-1:0]          addra,
  output logic                      enb,
  output logic [RD_AW-1:0]          addrb,
  output logic [RDW-1:0]            dout,
  output logic                      dout_valid,
  output logic [2:0]                sel,
  output logic [RD_AW-ROW_WL-1:0]   count,
  output logic                      complete
);

  localparam int LANES = RDW / DW;
  localparam int LW    = WR_AW - RD_AW;

  typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;

  state_t state;

  // Byte lanes packed into one word per entry, so a byte write and a word read address the same row.
  logic [LANES-1:0][DW-1:0] mem [2**RD_AW];

  always_ff @(posedge clk) begin
    if (wea) begin
      mem[addra[WR_AW-1:LW]][addra[LW-1:0]] <= din;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      ena        <= 1'b0;
      wea        <= 1'b0;
      addra      <= '0;
      enb        <= 1'b0;
      addrb      <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      sel        <= '0;
      count      <= '0;
      complete   <= 1'b0;
    end else begin
      dout_valid <= enb;
      complete   <= 1'b0;
      if (enb) begin
        dout  <= mem[addrb];
        sel   <= addrb[2:0];
        count <= addrb[RD_AW-1:ROW_WL];
      end
      case (state)
        IDLE: begin
          if (start) begin
            state <= WRITE;
            ena   <= 1'b1;
            wea   <= 1'b1;
            addra <= '0;
          end
        end
        WRITE: begin
          addra <= addra + WR_AW'(1);
          if (&addra) begin
            state <= READ;
            ena   <= 1'b0;
            wea   <= 1'b0;
            enb   <= 1'b1;
            addrb <= '0;
          end
        end
        READ: begin
          addrb <= addrb + RD_AW'(1);
          // Last word: complete lines up with dout_valid for word 2**RD_AW-1 in DONE.
          if (&addrb) begin
            state    <= DONE;
            enb      <= 1'b0;
            complete <= 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_line_buffer.sv
// Directed bench for frame_line_buffer: ramp frame, back-to-back frame, mid-frame abort.
module tb_frame_line_buffer;

  logic        clk;
  logic        reset;
  logic        start;
  logic [7:0]  din;
  logic        ena, wea, enb, dout_valid, complete;
  logic [10:0] addra;
  logic [8:0]  addrb;
  logic [31:0] dout;
  logic [2:0]  sel;
  logic [4:0]  count;
  logic [7:0]  key;

  frame_line_buffer dut (
    .clk(clk), .reset(reset), .start(start), .din(din),
    .ena(ena), .wea(wea), .addra(addra), .enb(enb), .addrb(addrb),
    .dout(dout), .dout_valid(dout_valid), .sel(sel), .count(count),
    .complete(complete)
  );

  assign din = addra[7:0] ^ key;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          frm;
    int          word;
    logic [31:0] dat;
    logic [2:0]  sel;
    logic [4:0]  cnt;
  } vec_t;

  vec_t tbl[9];

  int pass_n  = 0;
  int total_n = 0;

  int wea_first, wea_last, wea_n, first_addra;
  int enb_first, enb_last, enb_n;
  int cmp_n, cmp_cyc, vld_n;
  logic done_vld;
  logic [2:0] done_sel;
  logic [4:0] done_cnt;
  logic [31:0] cap_dout [512];
  logic [2:0]  cap_sel  [512];
  logic [4:0]  cap_cnt  [512];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total_n++;
    if (act === exp) pass_n++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  function automatic logic [31:0] exp_word(input logic [7:0] k8, input int k);
    logic [31:0] w;
    logic [10:0] a;
    for (int j = 0; j < 4; j++) begin
      a = 11'(4 * k + j);
      w[8*j +: 8] = a[7:0] ^ k8;
    end
    return w;
  endfunction

  // Samples every cycle of one frame (cycles off..2562), cycle 0 being the one in which start is sampled.
  task automatic run_frame(input int off);
    int rel;
    wea_first = -1; wea_last = -1; wea_n = 0; first_addra = -1;
    enb_first = -1; enb_last = -1; enb_n = 0;
    cmp_n = 0; cmp_cyc = -1; vld_n = 0;
    done_vld = 1'b0; done_sel = '0; done_cnt = '0;
    for (int n = 1; n <= 2563 - off; n++) begin
      @(negedge clk);
      rel = n - 1 + off;
      if (wea) begin
        if (wea_n == 0) begin
          wea_first   = rel;
          first_addra = int'(addra);
        end
        wea_last = rel;
        wea_n++;
      end
      if (enb) begin
        if (enb_n == 0) enb_first = rel;
        enb_last = rel;
        enb_n++;
      end
      if (dout_valid && vld_n < 512) begin
        cap_dout[vld_n] = dout;
        cap_sel[vld_n]  = sel;
        cap_cnt[vld_n]  = count;
        vld_n++;
      end
      if (complete) begin
        cmp_n++;
        cmp_cyc  = rel;
        done_vld = dout_valid;
        done_sel = sel;
        done_cnt = count;
      end
    end
    check("complete_pulses", cmp_n, 1);
  endtask

  task automatic check_frame(input int frm, input logic [7:0] k8);
    int errs;
    errs = 0;
    for (int k = 0; k < 512; k++) begin
      if (cap_dout[k] !== exp_word(k8, k) || cap_sel[k] !== 3'(k) || cap_cnt[k] !== 5'(k >> 4))
        errs++;
    end
    check($sformatf("frame%0d_word_errors", frm), errs, 0);
    check($sformatf("frame%0d_valid_words", frm), vld_n, 512);
    for (int i = 0; i < 9; i++) begin
      if (tbl[i].frm == frm) begin
        check($sformatf("f%0d_w%0d_dout", frm, tbl[i].word), cap_dout[tbl[i].word], tbl[i].dat);
        check($sformatf("f%0d_w%0d_sel", frm, tbl[i].word), cap_sel[tbl[i].word], tbl[i].sel);
        check($sformatf("f%0d_w%0d_count", frm, tbl[i].word), cap_cnt[tbl[i].word], tbl[i].cnt);
      end
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ctrl"}, {ena, wea, enb, dout_valid, complete}, 0);
    check({tag, "_addr"}, {addra, addrb}, 0);
    check({tag, "_data"}, {dout, sel, count}, 0);
  endtask

  initial begin
    tbl[0] = '{0, 0,   32'h03020100, 3'd0, 5'd0};
    tbl[1] = '{0, 1,   32'h07060504, 3'd1, 5'd0};
    tbl[2] = '{0, 17,  32'h47464544, 3'd1, 5'd1};
    tbl[3] = '{0, 255, 32'hFFFEFDFC, 3'd7, 5'd15};
    tbl[4] = '{0, 511, 32'hFFFEFDFC, 3'd7, 5'd31};
    tbl[5] = '{1, 0,   32'h59585B5A, 3'd0, 5'd0};
    tbl[6] = '{1, 1,   32'h5D5C5F5E, 3'd1, 5'd0};
    tbl[7] = '{1, 511, 32'hA5A4A7A6, 3'd7, 5'd31};
    tbl[8] = '{2, 16,  32'h80818283, 3'd0, 5'd1};

    reset = 1'b1;
    start = 1'b0;
    key   = 8'h00;
    #3;
    check_zero("reset");
    @(posedge clk); #1;
    reset = 1'b0;

    // Frame 0: ramp, start held high into frame 1.
    @(posedge clk); #1;
    start = 1'b1;
    run_frame(0);
    check("f0_wea_first", wea_first, 1);
    check("f0_wea_last", wea_last, 2048);
    check("f0_wea_cycles", wea_n, 2048);
    check("f0_first_addra", first_addra, 0);
    check("f0_enb_first", enb_first, 2049);
    check("f0_enb_last", enb_last, 2560);
    check("f0_enb_cycles", enb_n, 512);
    check("f0_complete_cycle", cmp_cyc, 2561);
    check("f0_done_flags", {done_vld, done_sel, done_cnt}, {1'b1, 3'd7, 5'd31});
    check_frame(0, 8'h00);

    // Frame 1: back-to-back with a different pattern; its cycle 0 was already sampled above.
    key = 8'h5A;
    run_frame(1);
    start = 1'b0;
    check("f1_wea_first", wea_first, 1);
    check("f1_enb_last", enb_last, 2560);
    check("f1_complete_cycle", cmp_cyc, 2561);
    check_frame(1, 8'h5A);

    repeat (3) @(negedge clk);
    check("hold_dout", dout, 32'hA5A4A7A6);
    check("hold_idle", {dout_valid, wea, enb, complete}, 0);

    // Abort mid-write, then a fresh frame must start from address 0.
    @(posedge clk); #1;
    start = 1'b1;
    begin
      int guard;
      guard = 0;
      while (addra != 11'd1000 && guard < 1100) begin
        @(negedge clk);
        guard++;
      end
    end
    check("abort_reach_1000", addra, 11'd1000);
    start = 1'b0;
    #2 reset = 1'b1;
    #1;
    check_zero("abort");
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort_no_complete", complete, 0);
    key   = 8'hC3;
    start = 1'b1;
    run_frame(0);
    start = 1'b0;
    check("f2_wea_first", wea_first, 1);
    check("f2_first_addra", first_addra, 0);
    check("f2_complete_cycle", cmp_cyc, 2561);
    check_frame(2, 8'hC3);

    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end

endmodule
